// File: rtl/maf_mul_sched.sv
// Issue scheduler for the 24x24 partial-product multiplier array: arbitration, half-op
// packing, LAT-delayed result tags and credit gating. Optional perf counters: MUL_SCHED_PERF_EN.
module maf_mul_sched #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned LAT     = 2,
  parameter int unsigned CREDITS = 4
`ifdef MUL_SCHED_PERF_EN
  ,
  parameter int unsigned CNT_W   = 16
`endif
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             r0_valid_i,
  input  logic                             r0_fp32_i,
  input  logic [WIDTH-1:0]                 r0_a_i,
  input  logic [WIDTH-1:0]                 r0_b_i,
  output logic                             r0_ready_o,
  input  logic                             r1_valid_i,
  input  logic [10:0]                      r1_a_i,
  input  logic [10:0]                      r1_b_i,
  output logic                             r1_ready_o,
  output logic [2:0]                       cont_o,
  output logic [WIDTH-1:0]                 m_a_o,
  output logic [WIDTH-1:0]                 m_b_o,
  output logic                             iss_valid_o,
  input  logic                             ret_ack_i,
  output logic                             tag_valid_o,
  output logic [2:0]                       tag_cont_o,
  output logic                             tag_lo_r1_o,
  output logic [$clog2(CREDITS+1)-1:0]     credits_o,
  output logic                             err_o
`ifdef MUL_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]                 perf_issue_o,
  output logic [CNT_W-1:0]                 perf_pair_o
`endif
);

  localparam int unsigned HALF_W = 11;
  localparam int unsigned CRED_W = $clog2(CREDITS+1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  localparam logic [2:0] CONT_FULL   = 3'b000;
  localparam logic [2:0] CONT_DUAL   = 3'b001;
  localparam logic [2:0] CONT_SINGLE = 3'b010;
  localparam logic [2:0] CONT_IDLE   = 3'b011;

  typedef struct packed {
    logic       vld;
    logic [2:0] cont;
    logic       lo_r1;
  } tag_t;

  logic             prio_q, prio_d;
  logic [2:0]       cont_q, cont_d;
  logic [WIDTH-1:0] m_a_q, m_a_d, m_b_q, m_b_d;
  logic             iss_q, iss_d;
  logic             lo_r1_q, lo_r1_d;
  logic [CRED_W-1:0] cred_q, cred_d;
  logic             err_q, err_d;
  tag_t             tag_q [LAT];

  logic gnt0, gnt1, issue;

  // Lo half in [10:0], hi half in [22:12]; guard bits 11 and 23 stay zero.
  function automatic logic [WIDTH-1:0] pack_halves(input logic [HALF_W-1:0] lo,
                                                   input logic [HALF_W-1:0] hi);
    logic [WIDTH-1:0] w;
    w = '0;
    w[HALF_W-1:0]        = lo;
    w[2*HALF_W:HALF_W+1] = hi;
    return w;
  endfunction

  // Grant: pair r0-half with r1, otherwise prio decides an fp32/r1 conflict.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (cred_q != '0) begin
      gnt0 = r0_valid_i & (~r1_valid_i | ~r0_fp32_i | ~prio_q);
      gnt1 = r1_valid_i & (~r0_valid_i | ~r0_fp32_i | prio_q);
    end
    issue = gnt0 | gnt1;
  end

  assign r0_ready_o = gnt0;
  assign r1_ready_o = gnt1;

  // Next issue register contents.
  always_comb begin
    cont_d  = CONT_IDLE;
    iss_d   = 1'b0;
    lo_r1_d = 1'b0;
    m_a_d   = m_a_q;
    m_b_d   = m_b_q;
    prio_d  = prio_q;
    if (gnt0 && gnt1) begin
      cont_d = CONT_DUAL;
      iss_d  = 1'b1;
      m_a_d  = pack_halves(r0_a_i[HALF_W-1:0], r1_a_i);
      m_b_d  = pack_halves(r0_b_i[HALF_W-1:0], r1_b_i);
    end else if (gnt0) begin
      iss_d = 1'b1;
      if (r0_fp32_i) begin
        cont_d = CONT_FULL;
        m_a_d  = r0_a_i;
        m_b_d  = r0_b_i;
      end else begin
        cont_d = CONT_SINGLE;
        m_a_d  = pack_halves(r0_a_i[HALF_W-1:0], '0);
        m_b_d  = pack_halves(r0_b_i[HALF_W-1:0], '0);
      end
      if (r1_valid_i) prio_d = ~prio_q;
    end else if (gnt1) begin
      cont_d  = CONT_SINGLE;
      iss_d   = 1'b1;
      lo_r1_d = 1'b1;
      m_a_d   = pack_halves(r1_a_i, '0);
      m_b_d   = pack_halves(r1_b_i, '0);
      if (r0_valid_i) prio_d = ~prio_q;
    end
  end

  // Credit accounting; a return with nothing outstanding is dropped and flagged.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    if (ret_ack_i && (cred_q == CRED_MAX)) begin
      err_d = 1'b1;
      if (issue) cred_d = cred_q - CRED_W'(1);
    end else if (issue && !ret_ack_i) begin
      cred_d = cred_q - CRED_W'(1);
    end else if (!issue && ret_ack_i) begin
      cred_d = cred_q + CRED_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q  <= 1'b0;
      cont_q  <= CONT_IDLE;
      m_a_q   <= '0;
      m_b_q   <= '0;
      iss_q   <= 1'b0;
      lo_r1_q <= 1'b0;
      cred_q  <= CRED_MAX;
      err_q   <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      cont_q  <= cont_d;
      m_a_q   <= m_a_d;
      m_b_q   <= m_b_d;
      iss_q   <= iss_d;
      lo_r1_q <= lo_r1_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

  // Tag delay line aligned with the array result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {iss_q, cont_q, lo_r1_q};
      for (int unsigned i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign cont_o      = cont_q;
  assign m_a_o       = m_a_q;
  assign m_b_o       = m_b_q;
  assign iss_valid_o = iss_q;
  assign tag_valid_o = tag_q[LAT-1].vld;
  assign tag_cont_o  = tag_q[LAT-1].cont;
  assign tag_lo_r1_o = tag_q[LAT-1].lo_r1;
  assign credits_o   = cred_q;
  assign err_o       = err_q;

`ifdef MUL_SCHED_PERF_EN
  logic [CNT_W-1:0] perf_issue_q, perf_pair_q;

  // Saturating issue / paired-issue counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_issue_q <= '0;
      perf_pair_q  <= '0;
    end else begin
      if (issue && (perf_issue_q != '1)) perf_issue_q <= perf_issue_q + CNT_W'(1);
      if (gnt0 && gnt1 && (perf_pair_q != '1)) perf_pair_q <= perf_pair_q + CNT_W'(1);
    end
  end

  assign perf_issue_o = perf_issue_q;
  assign perf_pair_o  = perf_pair_q;
`endif

endmodule
